// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle: pipeline-side inputs and control outputs.
// master: pipeline/testbench side; slave: the hazard unit.
interface hazard_unit_if;
  logic [4:0]  rs1_IF_ID_in;
  logic [4:0]  rs2_IF_ID_in;
  logic [4:0]  rd_ID_EX_in;
  logic        MemRead_ID_EX_in;
  logic        branch_taken_EX_in;
  logic        dmem_req_in;
  logic        dmem_ready_in;
  logic        PCWrite_out;
  logic        IF_ID_Write_out;
  logic        ID_EX_Bubble_out;
  logic        IF_ID_Flush_out;
  logic        ID_EX_Flush_out;
  logic        Pipe_Freeze_out;
  logic        mem_timeout_out;
  logic [31:0] stall_cnt_out;

  modport master (
    output rs1_IF_ID_in, rs2_IF_ID_in, rd_ID_EX_in, MemRead_ID_EX_in,
           branch_taken_EX_in, dmem_req_in, dmem_ready_in,
    input  PCWrite_out, IF_ID_Write_out, ID_EX_Bubble_out, IF_ID_Flush_out,
           ID_EX_Flush_out, Pipe_Freeze_out, mem_timeout_out, stall_cnt_out
  );

  modport slave (
    input  rs1_IF_ID_in, rs2_IF_ID_in, rd_ID_EX_in, MemRead_ID_EX_in,
           branch_taken_EX_in, dmem_req_in, dmem_ready_in,
    output PCWrite_out, IF_ID_Write_out, ID_EX_Bubble_out, IF_ID_Flush_out,
           ID_EX_Flush_out, Pipe_Freeze_out, mem_timeout_out, stall_cnt_out
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory-wait freeze, taken-branch flush, load-use stall,
// sticky data-memory timeout flag.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating stall-cycle counter;
// without it stall_cnt_out is tied to zero.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 255  // legal range 2..255
) (
  input logic          clk,
  input logic          rst_n,
  hazard_unit_if.slave hz
);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       freeze;
  logic       load_use;
  logic       pc_write, if_id_write, bubble, if_id_flush, id_ex_flush;

  // Hazard detection terms
  always_comb begin
    freeze   = hz.dmem_req_in & ~hz.dmem_ready_in;
    load_use = hz.MemRead_ID_EX_in && (hz.rd_ID_EX_in != 5'd0) &&
               ((hz.rd_ID_EX_in == hz.rs1_IF_ID_in) || (hz.rd_ID_EX_in == hz.rs2_IF_ID_in));
  end

  // Control outputs, priority: freeze > taken branch > load-use
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    bubble      = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (freeze) begin
      // A branch held across the freeze is flushed in the first unfrozen cycle
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (hz.branch_taken_EX_in) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
    end
  end

  // Drive the interface outputs
  always_comb begin
    hz.PCWrite_out      = pc_write;
    hz.IF_ID_Write_out  = if_id_write;
    hz.ID_EX_Bubble_out = bubble;
    hz.IF_ID_Flush_out  = if_id_flush;
    hz.ID_EX_Flush_out  = id_ex_flush;
    hz.Pipe_Freeze_out  = freeze;
    hz.mem_timeout_out  = timeout_q;
  end

  // Next state: wait FSM, wait counter and sticky timeout flag
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    timeout_d  = timeout_q;
    unique case (state_q)
      StRun:     if (freeze) state_d = StMemWait;
      StMemWait: if (!freeze) state_d = StRun;
      default:   state_d = StRun;
    endcase
    if (freeze) begin
      // First frozen cycle always sees a cleared count
      wait_cnt_d = (state_q == StMemWait) ? wait_cnt_q + 8'd1 : 8'd1;
      if (wait_cnt_q == WaitLimit) timeout_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign hz.stall_cnt_out = stall_cnt_q;
`else
  assign hz.stall_cnt_out = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MEM_TIMEOUT=4) with a behavioural model.
module tb_hazard_unit;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  int      m_waits = 0;   // consecutive frozen edges so far
  bit      m_to    = 1'b0;
  longint  m_stall = 0;

  hazard_unit_if hz ();

  hazard_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // Observed control vector {PCWrite, IF_ID_Write, Bubble, IF_ID_Flush, ID_EX_Flush, Freeze}
  function automatic logic [5:0] obs_ctrl();
    return {hz.PCWrite_out, hz.IF_ID_Write_out, hz.ID_EX_Bubble_out,
            hz.IF_ID_Flush_out, hz.ID_EX_Flush_out, hz.Pipe_Freeze_out};
  endfunction

  // Expected control vector from the hazard rules
  function automatic logic [5:0] exp_ctrl();
    bit fr, lu;
    fr = hz.dmem_req_in && !hz.dmem_ready_in;
    lu = hz.MemRead_ID_EX_in && hz.rd_ID_EX_in != 0 &&
         (hz.rd_ID_EX_in == hz.rs1_IF_ID_in || hz.rd_ID_EX_in == hz.rs2_IF_ID_in);
    if (fr)                        return 6'b000001;
    if (hz.branch_taken_EX_in)     return 6'b110110;
    if (lu)                        return 6'b001000;
    return 6'b110000;
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef HAZARD_STALL_CNT_EN
    return (m_stall > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stall);
`else
    return 32'd0;
`endif
  endfunction

  task automatic set_idle();
    hz.rs1_IF_ID_in       = 5'd0;
    hz.rs2_IF_ID_in       = 5'd0;
    hz.rd_ID_EX_in        = 5'd0;
    hz.MemRead_ID_EX_in   = 1'b0;
    hz.branch_taken_EX_in = 1'b0;
    hz.dmem_req_in        = 1'b0;
    hz.dmem_ready_in      = 1'b0;
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge
  task automatic step();
    logic [5:0] c;
    c = exp_ctrl();
    @(posedge clk);
    if (rst_n) begin
      if (c[0]) begin
        m_waits++;
        if (m_waits >= TO) m_to = 1'b1;
      end else begin
        m_waits = 0;
      end
      if (!c[5]) m_stall++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    m_waits = 0;
    m_to    = 1'b0;
    m_stall = 0;
    rst_n   = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110000) begin
      $display("FAIL reset_ctrl: got %b want %b", obs_ctrl(), 6'b110000); fails++;
    end
    tests++;
    if (hz.mem_timeout_out !== 1'b0 || hz.stall_cnt_out !== 32'd0) begin
      $display("FAIL reset_regs: got to=%b stall=%0d want 0 0", hz.mem_timeout_out,
               hz.stall_cnt_out); fails++;
    end
    do_reset();
  endtask

  task automatic test_load_use();
    set_idle();
    hz.MemRead_ID_EX_in = 1'b1; hz.rd_ID_EX_in = 5'd5; hz.rs1_IF_ID_in = 5'd5;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b001000) begin
      $display("FAIL load_use_rs1: got %b want %b", obs_ctrl(), 6'b001000); fails++;
    end
    step();
    set_idle();  // bubble inserted: EX now holds a NOP
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110000) begin
      $display("FAIL load_use_one_cycle: got %b want %b", obs_ctrl(), 6'b110000); fails++;
    end
    hz.MemRead_ID_EX_in = 1'b1; hz.rd_ID_EX_in = 5'd0; hz.rs1_IF_ID_in = 5'd0;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110000) begin
      $display("FAIL load_use_x0: got %b want %b", obs_ctrl(), 6'b110000); fails++;
    end
    hz.rd_ID_EX_in = 5'd9; hz.rs2_IF_ID_in = 5'd9; hz.rs1_IF_ID_in = 5'd3;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b001000) begin
      $display("FAIL load_use_rs2: got %b want %b", obs_ctrl(), 6'b001000); fails++;
    end
    hz.MemRead_ID_EX_in = 1'b0;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110000) begin
      $display("FAIL no_load: got %b want %b", obs_ctrl(), 6'b110000); fails++;
    end
    step();
  endtask

  task automatic test_branch_vs_loaduse();
    set_idle();
    hz.branch_taken_EX_in = 1'b1;
    hz.MemRead_ID_EX_in = 1'b1; hz.rd_ID_EX_in = 5'd7; hz.rs2_IF_ID_in = 5'd7;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110110) begin
      $display("FAIL branch_vs_loaduse: got %b want %b", obs_ctrl(), 6'b110110); fails++;
    end
    step();
    set_idle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_idle();
    hz.dmem_req_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (obs_ctrl() !== 6'b000001) begin
        $display("FAIL mem_wait_frozen[%0d]: got %b want %b", i, obs_ctrl(), 6'b000001);
        fails++;
      end
      step();
    end
    hz.dmem_ready_in = 1'b1;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110000) begin
      $display("FAIL mem_wait_release: got %b want %b", obs_ctrl(), 6'b110000); fails++;
    end
    tests++;
`ifdef HAZARD_STALL_CNT_EN
    if (hz.stall_cnt_out !== 32'd3) begin
      $display("FAIL mem_wait_stall_cnt: got %0d want 3", hz.stall_cnt_out); fails++;
    end
`else
    if (hz.stall_cnt_out !== 32'd0) begin
      $display("FAIL mem_wait_stall_cnt: got %0d want 0", hz.stall_cnt_out); fails++;
    end
`endif
    step();
    set_idle();
  endtask

  task automatic test_timeout();
    do_reset();
    set_idle();
    hz.dmem_req_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (hz.mem_timeout_out !== (i >= 4)) begin
        $display("FAIL timeout_edge[%0d]: got %b want %b", i, hz.mem_timeout_out, i >= 4);
        fails++;
      end
      step();
    end
    hz.dmem_ready_in = 1'b1;
    step();
    step();
    tests++;
    if (hz.mem_timeout_out !== 1'b1) begin
      $display("FAIL timeout_sticky: got %b want 1", hz.mem_timeout_out); fails++;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (hz.mem_timeout_out !== 1'b0) begin
      $display("FAIL timeout_clear: got %b want 0", hz.mem_timeout_out); fails++;
    end
    do_reset();
    set_idle();
  endtask

  task automatic test_branch_during_freeze();
    set_idle();
    hz.branch_taken_EX_in = 1'b1;
    hz.dmem_req_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (obs_ctrl() !== 6'b000001) begin
        $display("FAIL branch_frozen[%0d]: got %b want %b", i, obs_ctrl(), 6'b000001);
        fails++;
      end
      step();
    end
    hz.dmem_ready_in = 1'b1;
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110110) begin
      $display("FAIL branch_after_freeze: got %b want %b", obs_ctrl(), 6'b110110); fails++;
    end
    step();
    set_idle();
    #1;
    tests++;
    if (obs_ctrl() !== 6'b110000) begin
      $display("FAIL branch_flush_once: got %b want %b", obs_ctrl(), 6'b110000); fails++;
    end
  endtask

  task automatic test_mid_wait_reset();
    do_reset();
    set_idle();
    hz.dmem_req_in = 1'b1;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (hz.stall_cnt_out !== 32'd0 || hz.mem_timeout_out !== 1'b0) begin
      $display("FAIL mid_wait_reset: got stall=%0d to=%b want 0 0", hz.stall_cnt_out,
               hz.mem_timeout_out); fails++;
    end
    m_waits = 0; m_to = 1'b0; m_stall = 0;
    rst_n = 1'b1;
    // Wait count must restart from zero: three more frozen edges stay below the limit
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (hz.mem_timeout_out !== 1'b0) begin
      $display("FAIL mid_wait_restart: got %b want 0", hz.mem_timeout_out); fails++;
    end
    step();
    tests++;
    if (hz.mem_timeout_out !== 1'b1) begin
      $display("FAIL mid_wait_limit: got %b want 1", hz.mem_timeout_out); fails++;
    end
    do_reset();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      hz.rs1_IF_ID_in       = 5'($urandom_range(0, 3));
      hz.rs2_IF_ID_in       = 5'($urandom_range(0, 3));
      hz.rd_ID_EX_in        = 5'($urandom_range(0, 3));
      hz.MemRead_ID_EX_in   = 1'($urandom_range(0, 1));
      hz.branch_taken_EX_in = ($urandom_range(0, 3) == 0);
      hz.dmem_req_in        = 1'($urandom_range(0, 1));
      hz.dmem_ready_in      = ($urandom_range(0, 2) != 0);
      #1;
      tests++;
      if (obs_ctrl() !== exp_ctrl() || hz.mem_timeout_out !== m_to ||
          hz.stall_cnt_out !== exp_stall()) begin
        $display("FAIL random[%0d]: got ctrl=%b to=%b stall=%0d want ctrl=%b to=%b stall=%0d",
                 i, obs_ctrl(), hz.mem_timeout_out, hz.stall_cnt_out, exp_ctrl(), m_to,
                 exp_stall());
        fails++;
      end
      step();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    @(posedge clk); #1;
    test_load_use();
    test_branch_vs_loaduse();
    test_mem_wait();
    test_timeout();
    test_branch_during_freeze();
    test_mid_wait_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255; maximum consecutive data-memory wait cycles before the error flag sets; legal range 2..255.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 rs1_IF_ID_in / rs2_IF_ID_in  input  5 each  source register indices of the instruction in ID.
REQ-005 rd_ID_EX_in  input  5  destination register index of the instruction in EX.
REQ-006 MemRead_ID_EX_in  input  1  the instruction in EX is a load.
REQ-007 branch_taken_EX_in  input  1  the branch in EX resolved as taken.
REQ-008 dmem_req_in / dmem_ready_in  input  1 each  MEM-stage access request / memory completion.
REQ-009 PCWrite_out, IF_ID_Write_out  output  1 each  PC and IF/ID register update enables.
REQ-010 ID_EX_Bubble_out  output  1  zero the control fields of ID/EX (insert a NOP).
REQ-011 IF_ID_Flush_out, ID_EX_Flush_out  output  1 each  squash the wrong-path instructions.
REQ-012 Pipe_Freeze_out  output  1  hold EX/MEM, MEM/WB and all upstream registers.
REQ-013 mem_timeout_out  output  1  sticky error flag for a data-memory wait timeout.
REQ-014 stall_cnt_out  output  32  stall-cycle performance counter.

Function
REQ-015 freeze = dmem_req_in & ~dmem_ready_in; this combinational term drives Pipe_Freeze_out in the same cycle.
REQ-016 FSM states RUN and MEM_WAIT: RUN->MEM_WAIT when freeze=1; MEM_WAIT->RUN when freeze=0; no other transitions.
REQ-017 Freeze behaviour: while freeze=1, PCWrite_out=0, IF_ID_Write_out=0, Bubble=0 and both Flush outputs=0; freeze has the highest priority.
REQ-018 Branch flush: when branch_taken_EX_in=1 and freeze=0, IF_ID_Flush_out=1 and ID_EX_Flush_out=1 for that cycle, PCWrite_out=1, and load-use detection is suppressed.
REQ-019 A taken branch that coincides with freeze is not flushed in that cycle; it is re-evaluated in the first unfrozen cycle.
REQ-020 Load-use condition: MemRead_ID_EX_in=1, rd_ID_EX_in!=0, and rd_ID_EX_in equals rs1_IF_ID_in or rs2_IF_ID_in.
REQ-021 When the load-use condition holds, freeze=0 and there is no branch: PCWrite_out=0, IF_ID_Write_out=0, ID_EX_Bubble_out=1, each for exactly one cycle per occurrence.
REQ-022 With no hazard: PCWrite_out=1, IF_ID_Write_out=1, and all other control outputs 0.
REQ-023 wait_cnt (8-bit) increments in every freeze cycle and clears to 0 in any cycle with freeze=0.
REQ-024 When freeze=1 and wait_cnt=MEM_TIMEOUT-1, mem_timeout_out sets at the next edge and holds 1 until reset; the freeze continues regardless.
REQ-025 All outputs are functions of current inputs and state only; there are no combinational loops.

Reset
REQ-026 When rst_n=0: state=RUN, wait_cnt=0, mem_timeout_out=0, stall_cnt_out=0, all taking effect immediately.
REQ-027 Reset asserted in MEM_WAIT abandons the wait; after rst_n rises the FSM restarts in RUN and re-evaluates freeze.
REQ-028 During reset with idle inputs: PCWrite_out=1, IF_ID_Write_out=1, and all other outputs 0.

Configuration
REQ-029 Macro HAZARD_STALL_CNT_EN defined: stall_cnt_out increments by 1 in each cycle where PCWrite_out=0 and saturates at 32'hFFFF_FFFF.
REQ-030 Macro HAZARD_STALL_CNT_EN undefined: stall_cnt_out is constant 0, no counter flops exist, and all other behaviour is identical.

Verification
REQ-031 Load-use: MemRead=1, rd_ID_EX=5, rs1_IF_ID=5 for one cycle -> PCWrite=0, IF_ID_Write=0, Bubble=1 in that cycle only; the same stimulus with rd_ID_EX=0 -> no stall.
REQ-032 Branch vs load-use: branch_taken=1 together with the load-use condition on rs2 -> both Flush outputs=1, Bubble=0, PCWrite=1.
REQ-033 Memory wait: dmem_req=1, ready=0 for 3 cycles, then ready=1 -> Freeze=1 for exactly 3 cycles, state MEM_WAIT for 3 cycles, back to RUN; with the macro defined, stall_cnt=3.
REQ-034 Timeout: MEM_TIMEOUT=4, hold req=1 and ready=0 for 6 cycles -> mem_timeout_out rises after the 4th wait edge, stays 1 after ready, and clears only on rst_n=0.
REQ-035 Branch during freeze: branch_taken=1 over 2 frozen cycles, then unfrozen -> Flush outputs 0 while frozen, then 1 for one cycle.
REQ-036 Mid-wait reset: assert rst_n=0 asynchronously in the 2nd MEM_WAIT cycle -> state RUN, wait_cnt=0 and counters 0 immediately, before any clock edge.
